// File: rtl/ntt_pointwise_mul.sv
// Pointwise modular multiply of two 4-coefficient NTT frames (A then B) with one shared multiplier.
// Optional macro PWM_SCALE_EN: each product is also scaled by N_INV mod Q, taking 2 edges per coefficient.
module ntt_pointwise_mul #(
    parameter int unsigned     BITS  = 32,
    parameter longint unsigned Q     = 5,
    parameter longint unsigned N_INV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_d0,
    input  logic [BITS-1:0] in_d1,
    input  logic [BITS-1:0] in_d2,
    input  logic [BITS-1:0] in_d3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c0,
    output logic [BITS-1:0] c1,
    output logic [BITS-1:0] c2,
    output logic [BITS-1:0] c3,
    output logic            busy
);

    localparam logic [BITS-1:0]   QB = BITS'(Q);
    localparam logic [2*BITS-1:0] QW = {{BITS{1'b0}}, QB};

    typedef enum logic [1:0] {LOAD_A, LOAD_B, MUL, OUT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q;
    logic [BITS-1:0] a_q [4];
    logic [BITS-1:0] b_q [4];
    logic [BITS-1:0] c_q [4];
    logic [BITS-1:0] in_d [4];

    logic [BITS-1:0]   op_x, op_y, mul_res;
    logic [2*BITS-1:0] prod;
    logic              last_step;

    assign in_d[0] = in_d0;
    assign in_d[1] = in_d1;
    assign in_d[2] = in_d2;
    assign in_d[3] = in_d3;

`ifdef PWM_SCALE_EN
    localparam logic [BITS-1:0] NINV_B = BITS'(N_INV);

    logic            phase_q;
    logic [BITS-1:0] p_q;

    // Second phase reuses the multiplier to scale the held product by N_INV.
    assign op_x      = phase_q ? p_q    : a_q[idx_q];
    assign op_y      = phase_q ? NINV_B : b_q[idx_q];
    assign last_step = (idx_q == 2'd3) && phase_q;
`else
    assign op_x      = a_q[idx_q];
    assign op_y      = b_q[idx_q];
    assign last_step = (idx_q == 2'd3);
`endif

    // Full-width product so reduction sees every bit of a*b.
    assign prod    = {{BITS{1'b0}}, op_x} * {{BITS{1'b0}}, op_y};
    assign mul_res = BITS'(prod % QW);

    assign in_ready  = ((state_q == LOAD_A) || (state_q == LOAD_B)) && !rst;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q == MUL);

    assign c0 = c_q[0];
    assign c1 = c_q[1];
    assign c2 = c_q[2];
    assign c3 = c_q[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD_A;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (avoids a latch).
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (in_valid)  state_d = LOAD_B;
            LOAD_B:  if (in_valid)  state_d = MUL;
            MUL:     if (last_step) state_d = OUT;
            OUT:     if (out_ready) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            // NOTE: the operand/result arrays are small flop banks that must read back 0 after reset, so they are reset explicitly.
            for (int k = 0; k < 4; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
`ifdef PWM_SCALE_EN
            phase_q <= 1'b0;
            p_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge order-independent.
            case (state_q)
                LOAD_A: if (in_valid) begin
                    for (int k = 0; k < 4; k++) a_q[k] <= in_d[k] % QB;
                end
                LOAD_B: if (in_valid) begin
                    for (int k = 0; k < 4; k++) b_q[k] <= in_d[k] % QB;
                    idx_q <= '0;
`ifdef PWM_SCALE_EN
                    phase_q <= 1'b0;
`endif
                end
                MUL: begin
`ifdef PWM_SCALE_EN
                    if (phase_q) begin
                        c_q[idx_q] <= mul_res;
                        idx_q      <= idx_q + 2'd1;
                    end else begin
                        p_q <= mul_res;
                    end
                    phase_q <= ~phase_q;
`else
                    c_q[idx_q] <= mul_res;
                    idx_q      <= idx_q + 2'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Directed, table-driven bench for ntt_pointwise_mul (Q=5 instance plus a large-Q instance).
module tb_ntt_pointwise_mul;

`ifdef PWM_SCALE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif
    localparam longint unsigned BIG_Q   = 64'd4294967291;
    localparam longint unsigned BIG_INV = 64'd1073741823;

    typedef logic [3:0][31:0] frame_t;
    typedef struct {
        frame_t a;
        frame_t b;
        frame_t c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [31:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
    logic [31:0] c0, c1, c2, c3;

    logic        bg_in_valid = 1'b0, bg_out_ready = 1'b1;
    logic        bg_in_ready, bg_out_valid, bg_busy;
    logic [31:0] bg_d0 = '0, bg_d1 = '0, bg_d2 = '0, bg_d3 = '0;
    logic [31:0] bg_c0, bg_c1, bg_c2, bg_c3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ntt_pointwise_mul #(.BITS(32), .Q(5), .N_INV(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
        .out_valid(out_valid), .out_ready(out_ready),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .busy(busy)
    );

    ntt_pointwise_mul #(.BITS(32), .Q(BIG_Q), .N_INV(BIG_INV)) dut_big (
        .clk(clk), .rst(rst), .in_valid(bg_in_valid), .in_ready(bg_in_ready),
        .in_d0(bg_d0), .in_d1(bg_d1), .in_d2(bg_d2), .in_d3(bg_d3),
        .out_valid(bg_out_valid), .out_ready(bg_out_ready),
        .c0(bg_c0), .c1(bg_c1), .c2(bg_c2), .c3(bg_c3), .busy(bg_busy)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input int unsigned x0, x1, x2, x3);
        frame_t f;
        f[0] = x0; f[1] = x1; f[2] = x2; f[3] = x3;
        return f;
    endfunction

    // Expected values in the table are the unscaled hand-computed products mod 5.
    function automatic frame_t expect_c(input frame_t c);
        frame_t r = c;
`ifdef PWM_SCALE_EN
        for (int k = 0; k < 4; k++) r[k] = (c[k] * 32'd4) % 32'd5;
`endif
        return r;
    endfunction

    task automatic set_d(input frame_t f);
        in_d0 = f[0]; in_d1 = f[1]; in_d2 = f[2]; in_d3 = f[3];
    endtask

    task automatic check_c(input string name, input frame_t exp);
        check({name, ".c0"}, c0, exp[0]);
        check({name, ".c1"}, c1, exp[1]);
        check({name, ".c2"}, c2, exp[2]);
        check({name, ".c3"}, c3, exp[3]);
    endtask

    // Called #1 after an edge: A on the next edge, B on the following one.
    task automatic send_ab(input string name, input frame_t a, input frame_t b);
        in_valid = 1'b1;
        set_d(a);
        check({name, ".in_ready_a"}, in_ready, 1);
        @(posedge clk); #1;
        set_d(b);
        check({name, ".in_ready_b"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, ".busy"}, busy, 1);
        check({name, ".in_ready_mul"}, in_ready, 0);
    endtask

    task automatic wait_out(input string name);
        int cnt = 0;
        while (!out_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, ".latency"}, cnt, LAT);
        check({name, ".busy_out"}, busy, 0);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".out_valid_after"}, out_valid, 0);
        check({name, ".in_ready_after"}, in_ready, 1);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{a: mk(1, 2, 3, 4),  b: mk(4, 3, 2, 1), c: mk(4, 1, 1, 4)};
        vecs[1] = '{a: mk(7, 9, 5, 12), b: mk(3, 3, 3, 3), c: mk(1, 2, 0, 1)};
        vecs[2] = '{a: mk(0, 1, 4, 5),  b: mk(4, 4, 4, 4), c: mk(0, 4, 1, 0)};
        vecs[3] = '{a: mk(4, 4, 4, 4),  b: mk(4, 9, 14, 4), c: mk(1, 1, 1, 1)};

        // Reset state
        #12;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check_c("rst", mk(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.in_ready", in_ready, 1);

        // Table: vector 0 runs with out_ready already high before out_valid
        for (int i = 0; i < 4; i++) begin
            string nm = $sformatf("vec%0d", i);
            out_ready = (i == 0);
            send_ab(nm, vecs[i].a, vecs[i].b);
            wait_out(nm);
            check_c(nm, expect_c(vecs[i].c));
            handshake(nm);
        end

        // Backpressure: new data offered in OUT must be ignored
        send_ab("bp", mk(1, 2, 3, 4), mk(4, 3, 2, 1));
        wait_out("bp");
        in_valid = 1'b1;
        set_d(mk(3, 3, 3, 3));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d.out_valid", k), out_valid, 1);
            check($sformatf("bp.hold%0d.in_ready", k), in_ready, 0);
        end
        check_c("bp.stable", expect_c(mk(4, 1, 1, 4)));
        set_d(mk(1, 1, 1, 1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release.out_valid", out_valid, 0);
        check("bp.release.in_ready", in_ready, 1);
        check_c("bp.kept", expect_c(mk(4, 1, 1, 4)));
        @(posedge clk); #1;
        set_d(mk(2, 3, 4, 1));
        check("bp.b.in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("bp2");
        check_c("bp2", expect_c(mk(2, 3, 4, 1)));
        handshake("bp2");

        // Reset mid-MUL after two MUL edges
        send_ab("mid", mk(2, 2, 2, 2), mk(2, 2, 2, 2));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid.busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid.out_valid", out_valid, 0);
        check("mid.busy", busy, 0);
        check("mid.in_ready_in_rst", in_ready, 0);
        check_c("mid", mk(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid.in_ready_after", in_ready, 1);
        @(posedge clk); #1;
        send_ab("fresh", mk(1, 2, 3, 4), mk(4, 3, 2, 1));
        wait_out("fresh");
        check_c("fresh", expect_c(mk(4, 1, 1, 4)));
        handshake("fresh");

        // Large modulus: full 64-bit product path and input reduction
        begin
            int cnt = 0;
            bg_in_valid = 1'b1;
            bg_d0 = 32'd4294967290; bg_d1 = 32'd0; bg_d2 = 32'd1; bg_d3 = 32'd4294967295;
            check("big.in_ready", bg_in_ready, 1);
            @(posedge clk); #1;
            bg_d0 = 32'd4294967290; bg_d1 = 32'd5; bg_d2 = 32'd4294967290; bg_d3 = 32'd3;
            @(posedge clk); #1;
            bg_in_valid = 1'b0;
            while (!bg_out_valid && cnt < 30) begin
                @(posedge clk); #1;
                cnt++;
            end
            check("big.latency", cnt, LAT);
`ifdef PWM_SCALE_EN
            check("big.c0", bg_c0, 64'd1073741823);
            check("big.c1", bg_c1, 64'd0);
            check("big.c2", bg_c2, 64'd3221225468);
            check("big.c3", bg_c3, 64'd3);
`else
            check("big.c0", bg_c0, 64'd1);
            check("big.c1", bg_c1, 64'd0);
            check("big.c2", bg_c2, 64'd4294967290);
            check("big.c3", bg_c3, 64'd12);
`endif
            @(posedge clk); #1;
            check("big.out_valid_after", bg_out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_pointwise_mul.md
Name: ntt_pointwise_mul

Overview:
- Downstream stage of the 4-point NTT butterfly network.
- Consumes two consecutive 4-coefficient NTT-domain frames: first is polynomial A, second is polynomial B.
- Computes c_i = (a_i * b_i) mod Q with one shared modular multiplier, one coefficient per cycle.
- Presents the 4-coefficient product frame to the inverse-NTT stage over a valid/ready handshake.

Parameters:
- BITS, 32, coefficient width of all data ports.
- Q, 5, prime modulus; must satisfy 2 <= Q < 2^BITS.
- N_INV, 4, inverse of transform length mod Q (4^-1 mod 5 = 4); used only when PWM_SCALE_EN is defined.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_d0..in_d3 hold a valid frame.
- in_ready  out  1  block accepts a frame this cycle.
- in_d0, in_d1, in_d2, in_d3  in  BITS each  NTT output coefficients (b0..b3 of the butterfly stage).
- out_valid  out  1  c0..c3 hold a valid product frame.
- out_ready  in  1  downstream consumes the frame.
- c0, c1, c2, c3  out  BITS each  pointwise products mod Q.
- busy  out  1  high in MUL state.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; on assertion it immediately forces state=LOAD_A, index=0, all A/B registers=0, c0..c3=0, out_valid=0, busy=0.
- in_ready = (state==LOAD_A or state==LOAD_B) and not rst. It is combinational from state only and never depends on in_valid.
- A transfer occurs on a rising edge with in_valid && in_ready. Each captured word is reduced on capture (in_dk % Q), so operands are always < Q.
- LOAD_A: on transfer, capture into A registers and go to LOAD_B.
- LOAD_B: on transfer, capture into B registers, go to MUL, set index=0.
- MUL: each edge writes c[index] = (A[index]*B[index]) % Q and increments index.
  - The product is computed at full 2*BITS width; no truncation before the reduction.
  - After writing c3 (4th MUL edge), go to OUT and set out_valid=1.
  - Latency: out_valid is high 4 cycles after the B-accept edge.
- OUT: out_valid=1 and c0..c3 stay stable until an edge with out_ready=1. On that edge: out_valid=0, go to LOAD_A. The c registers keep their last values.
- No overlap: while in MUL or OUT, in_ready=0 and any in_valid is ignored. Throughput is one product frame per 2 transfers + 4 + handshake cycles.
- out_ready may be high before out_valid; it has no effect outside OUT.
- If in_valid is held high continuously in LOAD_A, the next two frames are accepted on consecutive edges as A, then B.
- Reset mid-operation (any state) discards the partial frame. The first frame after reset is always A.

Optional Feature:
- Macro: PWM_SCALE_EN.
- Defined: each MUL step takes 2 edges.
  - Edge 1: p = (A*B) % Q into a temp register.
  - Edge 2: c[index] = (p*N_INV) % Q.
  - MUL lasts 8 edges; out_valid rises 8 cycles after the B accept.
- Not defined: no scaling, 4-edge MUL, N_INV unused. The temp register is not generated.

Test Plan:
- Reset release, then A=(1,2,3,4), B=(4,3,2,1), out_ready=1 -> out_valid high 4 cycles after B accept; c=(4,1,1,4); in_ready returns high the cycle after the output transfer.
- Unreduced inputs: A=(7,9,5,12), B=(3,3,3,3) -> operands reduced to (2,4,0,2); c=(1,2,0,1).
- Backpressure: out_ready=0 for 10 cycles in OUT while in_valid=1 with new data -> c stable, in_ready=0, no frame captured. Release -> next accepted frame is treated as A.
- Reset asserted mid-MUL after 2 coefficients written -> out_valid=0, c=0, in_ready=1 after release; a fresh A/B pair then gives the correct result.
- PWM_SCALE_EN, Q=5, N_INV=4, A=(1,2,3,4), B=(4,3,2,1) -> c=(1,4,4,1) with 8-cycle latency.
- BITS=32, Q=4294967291, A0=B0=4294967290 (i.e. -1) -> c0=1, confirming the full 64-bit product path.
